// File: rtl/s1_cfg_loader_if.sv
// rtl/s1_cfg_loader_if.sv - bitstream handshake and committed-configuration bundle for s1_cfg_loader
interface s1_cfg_loader_if #(
  parameter int W = 32
);
  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_ready;
  logic [W-1:0] cfg_data;
  logic         cfg_done;
  logic         cfg_err;
  logic         busy;

  modport master (
    output cfg_start, cfg_valid, cfg_bit,
    input  cfg_ready, cfg_data, cfg_done, cfg_err, busy
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit,
    output cfg_ready, cfg_data, cfg_done, cfg_err, busy
  );
endinterface

// File: rtl/s1_cfg_loader.sv
// rtl/s1_cfg_loader.sv - serial writer for S1 cell data-select words with atomic commit
// Define S1_CFG_CHECKSUM_EN to require a nibble-XOR checksum trailer and enable cfg_err.
module s1_cfg_loader #(
  parameter int NUM_CELLS = 8,
  parameter int CELL_BITS = 4
) (
  input logic            clk,
  input logic            clr,
  s1_cfg_loader_if.slave cfg
);
  localparam int P  = NUM_CELLS * CELL_BITS;
  localparam int CW = $clog2(P + 1);
  localparam logic [CW-1:0] LAST_PAY = CW'(P - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t        state, state_nxt;
  logic [P-1:0]  shadow, shadow_nxt;
  logic [P-1:0]  data_q, data_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_q, done_nxt;

`ifdef S1_CFG_CHECKSUM_EN
  localparam logic [CW-1:0] LAST_CHK = CW'(CELL_BITS - 1);

  logic [CELL_BITS-1:0] csum_rx, csum_rx_nxt, csum_calc, csum_last;
  logic                 err_q, err_nxt;

  always_comb begin
    csum_calc = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      csum_calc = csum_calc ^ shadow[i*CELL_BITS +: CELL_BITS];
    end
  end

  // Includes the bit on the wire so the compare is final on the last trailer transfer
  assign csum_last = {csum_rx[CELL_BITS-2:0], cfg.cfg_bit};
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    cnt_nxt    = cnt;
    data_nxt   = data_q;
    done_nxt   = 1'b0;
`ifdef S1_CFG_CHECKSUM_EN
    csum_rx_nxt = csum_rx;
    err_nxt     = err_q;
`endif
    if (cfg.cfg_start) begin
      // Start outranks any bit presented in the same cycle, including a final one
      state_nxt  = SHIFT;
      shadow_nxt = '0;
      cnt_nxt    = '0;
`ifdef S1_CFG_CHECKSUM_EN
      csum_rx_nxt = '0;
      err_nxt     = 1'b0;
`endif
    end else if (cfg.cfg_valid) begin
      case (state)
        SHIFT: begin
          shadow_nxt = {shadow[P-2:0], cfg.cfg_bit};
          cnt_nxt    = cnt + CW'(1);
          if (cnt == LAST_PAY) begin
            cnt_nxt = '0;
`ifdef S1_CFG_CHECKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = IDLE;
            data_nxt  = shadow_nxt;
            done_nxt  = 1'b1;
`endif
          end
        end
`ifdef S1_CFG_CHECKSUM_EN
        CHECK: begin
          csum_rx_nxt = csum_last;
          cnt_nxt     = cnt + CW'(1);
          if (cnt == LAST_CHK) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
            if (csum_last == csum_calc) begin
              data_nxt = shadow;
              done_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      shadow <= '0;
      cnt    <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
      done_q <= done_nxt;
    end
  end

`ifdef S1_CFG_CHECKSUM_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      csum_rx <= '0;
      err_q   <= 1'b0;
    end else begin
      csum_rx <= csum_rx_nxt;
      err_q   <= err_nxt;
    end
  end

  assign cfg.cfg_err = err_q;
`else
  assign cfg.cfg_err = 1'b0;
`endif

  assign cfg.cfg_ready = (state != IDLE);
  assign cfg.busy      = (state != IDLE);
  assign cfg.cfg_data  = data_q;
  assign cfg.cfg_done  = done_q;
endmodule

// File: tb/tb_s1_cfg_loader.sv
// tb/tb_s1_cfg_loader.sv - scoreboard bench for s1_cfg_loader with random gaps and frames
module tb_s1_cfg_loader;
  localparam int NC = 2;
  localparam int CB = 4;
  localparam int P  = NC * CB;
`ifdef S1_CFG_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;

  s1_cfg_loader_if #(.W(P)) bus ();

  s1_cfg_loader #(.NUM_CELLS(NC), .CELL_BITS(CB)) dut (
    .clk (clk),
    .clr (clr),
    .cfg (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [P-1:0] exp_q[$];
  logic [P-1:0] model_data = '0;
  bit model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_csum(input logic [P-1:0] d);
    logic [3:0] c = 4'h0;
    for (int i = 0; i < NC; i++) c = c ^ 4'((d >> (4 * i)) % 16);
    return c;
  endfunction

  always @(negedge clk) begin
    if (clr === 1'b1 && bus.cfg_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got cfg_done=1 with data %0h, required no pulse at %0t",
                 bus.cfg_data, $time);
      end else begin
        chk("commit_data", 32'(bus.cfg_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int maxgap);
    int g;
    g = $urandom_range(0, maxgap);
    repeat (g) begin
      bus.cfg_valid = 1'b0;
      bus.cfg_bit   = 1'($urandom);
      tick();
    end
    bus.cfg_valid = 1'b1;
    bus.cfg_bit   = b;
    chk("ready_in_frame", 32'(bus.cfg_ready), 32'd1);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic start_pulse();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    model_err = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("err_cleared_by_start", 32'(bus.cfg_err), 32'd0);
  endtask

  task automatic send_frame(input logic [P-1:0] pay, input logic [3:0] cs,
                            input int maxgap, input bit abort_last);
    logic q[$];
    bit good;
    for (int i = P - 1; i >= 0; i--) q.push_back(pay[i]);
    if (CHK) for (int i = 3; i >= 0; i--) q.push_back(cs[i]);
    good = !CHK || (cs == ref_csum(pay));
    start_pulse();
    for (int k = 0; k < q.size(); k++) begin
      if (k == q.size() - 1) begin
        if (abort_last) begin
          bus.cfg_valid = 1'b1;
          bus.cfg_bit   = q[k];
          bus.cfg_start = 1'b1;
          tick();
          bus.cfg_start = 1'b0;
          bus.cfg_valid = 1'b0;
          model_err = 1'b0;
          chk("abort_no_done", 32'(bus.cfg_done), 32'd0);
          chk("abort_busy", 32'(bus.busy), 32'd1);
          chk("abort_data_held", 32'(bus.cfg_data), 32'(model_data));
          return;
        end
        if (good) exp_q.push_back(pay);
      end
      send_bit(q[k], maxgap);
    end
    if (good) model_data = pay;
    else model_err = 1'b1;
    chk("done_after_last", 32'(bus.cfg_done), 32'(good));
    chk("ready_after_frame", 32'(bus.cfg_ready), 32'd0);
    chk("busy_after_frame", 32'(bus.busy), 32'd0);
    chk("err_after_frame", 32'(bus.cfg_err), 32'(model_err));
    chk("data_after_frame", 32'(bus.cfg_data), 32'(model_data));
    tick();
    chk("done_one_cycle", 32'(bus.cfg_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [P-1:0] pay;
    logic [3:0] cs;
    clr = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    repeat (2) tick();
    chk("reset_data", 32'(bus.cfg_data), 32'd0);
    chk("reset_done", 32'(bus.cfg_done), 32'd0);
    chk("reset_err", 32'(bus.cfg_err), 32'd0);
    chk("reset_ready", 32'(bus.cfg_ready), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    clr = 1'b1;
    tick();

    send_frame(8'hA5, 4'h0, 0, 1'b0);
    send_frame(8'hA5, 4'hF, 0, 1'b0);
    send_frame(8'h3C, 4'hF, 3, 1'b0);

    repeat (4) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = 1'($urandom);
      chk("idle_ready_low", 32'(bus.cfg_ready), 32'd0);
      tick();
    end
    bus.cfg_valid = 1'b0;
    chk("idle_valid_ignored", 32'(bus.cfg_data), 32'(model_data));

    start_pulse();
    repeat (5) send_bit(1'($urandom), 1);
    send_frame(8'h5A, 4'hF, 0, 1'b0);

    send_frame(8'h96, ref_csum(8'h96), 1, 1'b1);
    send_frame(8'hC3, 4'hF, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      pay = P'($urandom);
      cs  = ref_csum(pay);
      if ($urandom_range(0, 3) == 0) cs = cs ^ 4'($urandom_range(1, 15));
      send_frame(pay, cs, $urandom_range(0, 2), 1'b0);
    end

    send_frame(8'hA5, 4'hF, 0, 1'b0);
    start_pulse();
    repeat (3) send_bit(1'($urandom), 0);
    #2;
    clr = 1'b0;
    #1;
    model_data = '0;
    model_err  = 1'b0;
    chk("async_rst_data", 32'(bus.cfg_data), 32'd0);
    chk("async_rst_done", 32'(bus.cfg_done), 32'd0);
    chk("async_rst_err", 32'(bus.cfg_err), 32'd0);
    chk("async_rst_ready", 32'(bus.cfg_ready), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    tick();
    clr = 1'b1;
    tick();
    send_frame(8'h69, 4'hF, 2, 1'b0);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
